// File: rtl/fifo_stream_drain_pkg.sv
// Shared widths, beat record and lane-parity helper for the FIFO stream drain.
package fifo_stream_drain_pkg;

  localparam int unsigned STREAM_W = 128;
  localparam int unsigned PARITY_W = 16;
  localparam int unsigned LANE_W   = 8;

  typedef struct packed {
    logic [STREAM_W-1:0] data;
    logic                last;
  } beat_t;

  localparam int unsigned BEAT_W = $bits(beat_t);

  // Bit i is set when byte lane i disagrees with its parity bit.
  function automatic logic [PARITY_W-1:0] lane_fail(input logic [STREAM_W-1:0] data,
                                                   input logic [PARITY_W-1:0] par,
                                                   input logic                odd);
    logic [PARITY_W-1:0] f;
    for (int unsigned i = 0; i < PARITY_W; i++) begin
      f[i] = (^data[i*LANE_W +: LANE_W]) ^ par[i] ^ odd;
    end
    return f;
  endfunction

endpackage

// File: rtl/stream_skid_reg.sv
// Two-entry skid buffer: output register plus one spare slot, with a registered upstream ready.
module stream_skid_reg #(
  parameter int unsigned WIDTH = 129
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic             r_out_valid;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] r_skid_data;
  logic             w_push;
  logic             w_xfer;

  // Ready depends only on the spare slot, so it never sees downstream ready.
  assign o_ready = !r_skid_valid;
  assign w_push  = i_valid && !r_skid_valid;
  assign w_xfer  = r_out_valid && i_ready;
  assign o_valid = r_out_valid;
  assign o_data  = r_out_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out_data   <= '0;
      r_skid_data  <= '0;
    end else if (w_xfer && r_skid_valid) begin
      r_out_data   <= r_skid_data;
      r_skid_valid <= 1'b0;
    end else if (w_push && (w_xfer || !r_out_valid)) begin
      r_out_valid <= 1'b1;
      r_out_data  <= i_data;
    end else if (w_push) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= i_data;
    end else if (w_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_stream_drain.sv
// Drains a FWFT FIFO into a registered valid/ready stream with burst tlast, parity check
// and a delivered-beat counter.
module fifo_stream_drain
  import fifo_stream_drain_pkg::*;
#(
  parameter int unsigned BURST_LEN    = 8,
  parameter bit          PARITY_CHECK = 1'b1,
  parameter bit          ODD_PARITY   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STREAM_W-1:0] fifo_dout,
  input  logic [PARITY_W-1:0] fifo_doutp,
  input  logic                fifo_empty,
  output logic                fifo_rd_en,
  output logic [STREAM_W-1:0] m_tdata,
  output logic                m_tvalid,
  output logic                m_tlast,
  input  logic                m_tready,
  input  logic                err_clr,
  output logic                parity_err,
  output logic [PARITY_W-1:0] parity_err_lanes,
  output logic [31:0]         beat_count
);

  localparam logic [7:0] LAST_CNT = 8'(BURST_LEN - 1);

  logic [7:0]          r_burst_cnt;
  logic                r_parity_err;
  logic [PARITY_W-1:0] r_lanes;
  logic [31:0]         r_beat_count;
  logic                w_fifo_avail;
  logic                w_skid_ready;
  logic                w_pop;
  logic [PARITY_W-1:0] w_fail;
  beat_t               w_in_beat;
  beat_t               w_out_beat;

  // Held off during reset so the FIFO is never popped into a buffer being cleared.
  assign w_fifo_avail   = !fifo_empty && !rst;
  assign w_pop          = w_fifo_avail && w_skid_ready;
  assign fifo_rd_en     = w_pop;
  assign w_in_beat.data = fifo_dout;
  assign w_in_beat.last = (r_burst_cnt == LAST_CNT);
  assign w_fail = (PARITY_CHECK && w_pop) ? lane_fail(fifo_dout, fifo_doutp, ODD_PARITY) : '0;

  stream_skid_reg #(
    .WIDTH (BEAT_W)
  ) u_skid (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (w_fifo_avail),
    .o_ready (w_skid_ready),
    .i_data  (w_in_beat),
    .o_valid (m_tvalid),
    .i_ready (m_tready),
    .o_data  (w_out_beat)
  );

  assign m_tdata          = w_out_beat.data;
  assign m_tlast          = w_out_beat.last;
  assign parity_err       = r_parity_err;
  assign parity_err_lanes = r_lanes;
  assign beat_count       = r_beat_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_burst_cnt  <= '0;
      r_beat_count <= '0;
    end else begin
      if (w_pop) begin
        r_burst_cnt <= (r_burst_cnt == LAST_CNT) ? 8'd0 : r_burst_cnt + 8'd1;
      end
      if (m_tvalid && m_tready) begin
        r_beat_count <= r_beat_count + 32'd1;
      end
    end
  end

  // A clear coinciding with a fresh error keeps only the fresh lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity_err <= 1'b0;
      r_lanes      <= '0;
    end else if (err_clr) begin
      r_parity_err <= |w_fail;
      r_lanes      <= w_fail;
    end else begin
      r_parity_err <= r_parity_err | (|w_fail);
      r_lanes      <= r_lanes | w_fail;
    end
  end

endmodule
